mem_copy_engine: RTL and testbench

- Initiator for the single-port word memory: owns its addr / enable_write / write_data / read_out port and copies a block of `len` words from `src_addr` to `dst_addr`.
- The memory read is combinational (same-cycle `read_out`) and the memory write commits at posedge clk. The engine therefore alternates a read cycle and a write cycle per word.
- Sits between the control/sequencer logic and the memory as a block-move (DMA-style) helper.

---
 rtl/mem_copy_engine_pkg.sv | 18 +
 rtl/mem_copy_engine.sv | 139 +++++++++++++
 tb/tb_mem_copy_engine.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_engine_pkg.sv
// Shared types and default sizing for the block-copy engine and its word memory.
package mem_copy_engine_pkg;

  localparam int unsigned AddrWidth       = 8;
  localparam int unsigned DataWidth       = 16;
  localparam int unsigned LenWidthDefault = 16;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] op_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } copy_state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Block-move initiator for the single-port word memory: one read cycle, one write cycle per word.
// Optional memmove-style backward copy on overlap is enabled with `define MEM_COPY_BACKWARD_EN.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned LenWidth = LenWidthDefault
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  addr_t               src_addr,
  input  addr_t               dst_addr,
  input  logic [LenWidth-1:0] len,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [LenWidth-1:0] words_done,
`ifdef MEM_COPY_BACKWARD_EN
  output logic                backward,
`endif
  output addr_t               mem_addr,
  output logic                mem_enable_write,
  output op_t                 mem_write_data,
  input  op_t                 mem_read_data
);

  copy_state_t         state_q, state_d;
  addr_t               cur_src_q, cur_src_d;
  addr_t               cur_dst_q, cur_dst_d;
  logic [LenWidth-1:0] rem_q, rem_d;
  logic [LenWidth-1:0] cnt_q, cnt_d;
  op_t                 data_q, data_d;
  logic                backward_q, backward_d;

`ifdef MEM_COPY_BACKWARD_EN
  // Overlap test is done one bit wider than both operands so src+len never wraps.
  localparam int unsigned OvWidth = ((AddrWidth > LenWidth) ? AddrWidth : LenWidth) + 1;
  logic [OvWidth-1:0] src_ext, dst_ext, end_ext;
  logic               overlap;

  always_comb begin
    src_ext = OvWidth'(src_addr);
    dst_ext = OvWidth'(dst_addr);
    end_ext = src_ext + OvWidth'(len);
    overlap = (dst_ext > src_ext) && (dst_ext < end_ext);
  end

  assign backward = backward_q;
`endif

  always_comb begin
    state_d          = state_q;
    cur_src_d        = cur_src_q;
    cur_dst_d        = cur_dst_q;
    rem_d            = rem_q;
    cnt_d            = cnt_q;
    data_d           = data_q;
    backward_d       = backward_q;
    start_ready      = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    words_done       = '0;
    mem_addr         = '0;
    mem_enable_write = 1'b0;

    unique case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          cur_src_d  = src_addr;
          cur_dst_d  = dst_addr;
          rem_d      = len;
          cnt_d      = '0;
          backward_d = 1'b0;
`ifdef MEM_COPY_BACKWARD_EN
          if (overlap) begin
            backward_d = 1'b1;
            cur_src_d  = src_addr + addr_t'(len) - addr_t'(1);
            cur_dst_d  = dst_addr + addr_t'(len) - addr_t'(1);
          end
`endif
          state_d = (len == '0) ? DONE : READ;
        end
      end
      READ: begin
        busy     = 1'b1;
        mem_addr = cur_src_q;
        data_d   = mem_read_data;
        state_d  = abort ? DONE : WRITE;
      end
      WRITE: begin
        busy             = 1'b1;
        mem_addr         = cur_dst_q;
        mem_enable_write = 1'b1;
        cnt_d            = cnt_q + LenWidth'(1);
        rem_d            = rem_q - LenWidth'(1);
        if (backward_q) begin
          cur_src_d = cur_src_q - addr_t'(1);
          cur_dst_d = cur_dst_q - addr_t'(1);
        end else begin
          cur_src_d = cur_src_q + addr_t'(1);
          cur_dst_d = cur_dst_q + addr_t'(1);
        end
        state_d = ((rem_q == LenWidth'(1)) || abort) ? DONE : READ;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        words_done = cnt_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_write_data = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_src_q  <= '0;
      cur_dst_q  <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      backward_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_src_q  <= cur_src_d;
      cur_dst_q  <= cur_dst_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      backward_q <= backward_d;
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed and randomized copies against an array-level model of the word memory.
module tb_mem_copy_engine;
  import mem_copy_engine_pkg::*;

  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_valid;
  logic          start_ready;
  addr_t         src_addr;
  addr_t         dst_addr;
  logic [LW-1:0] len_in;
  logic          abort;
  logic          busy;
  logic          done;
  logic [LW-1:0] words_done;
  addr_t         mem_addr;
  logic          mem_enable_write;
  op_t           mem_write_data;
  op_t           mem_read_data;
`ifdef MEM_COPY_BACKWARD_EN
  logic          backward;
`endif

  op_t mem   [256];
  op_t model [256];
  int  vectors     = 0;
  int  miscompares = 0;

  mem_copy_engine #(.LenWidth(LW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_valid     (start_valid),
    .start_ready     (start_ready),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .len             (len_in),
    .abort           (abort),
    .busy            (busy),
    .done            (done),
    .words_done      (words_done),
`ifdef MEM_COPY_BACKWARD_EN
    .backward        (backward),
`endif
    .mem_addr        (mem_addr),
    .mem_enable_write(mem_enable_write),
    .mem_write_data  (mem_write_data),
    .mem_read_data   (mem_read_data)
  );

  always #5 clk = ~clk;

  // Word memory responder: combinational read, write committed at posedge.
  assign mem_read_data = mem[mem_addr];
  always @(posedge clk) if (mem_enable_write) mem[mem_addr] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_overlap(input int src, input int dst, input int len);
`ifdef MEM_COPY_BACKWARD_EN
    return (dst > src) && (dst < src + len);
`else
    return 1'b0;
`endif
  endfunction

  // Applies the first k word moves of a copy, in the order the engine performs them.
  task automatic model_copy(input int src, input int dst, input int len, input int k);
    if (model_overlap(src, dst, len)) begin
      for (int i = 0; i < k; i++) model[(dst + len - 1 - i) & 255] = model[(src + len - 1 - i) & 255];
    end else begin
      for (int i = 0; i < k; i++) model[(dst + i) & 255] = model[(src + i) & 255];
    end
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model[i]) bad++;
    check(tag, bad, 0);
  endtask

  // abort_cycle counts cycles after the accept edge (cycle 1 = first READ); 0 = no abort.
  task automatic run_copy(input int src, input int dst, input int len, input int abort_cycle);
    int k, exp_done, got, writes;
    logic [LW-1:0] wd;
    if (abort_cycle > 0 && abort_cycle <= 2 * len) begin
      k = abort_cycle / 2;
      exp_done = abort_cycle + 1;
    end else begin
      k = len;
      exp_done = 2 * len + 1;
    end
    start_valid = 1'b1;
    src_addr    = addr_t'(src);
    dst_addr    = addr_t'(dst);
    len_in      = LW'(len);
    @(negedge clk);
    check("start_ready_idle", start_ready, 1);
    check("mem_addr_idle", mem_addr, 0);
    @(posedge clk); #1;
    start_valid = 1'b0;
    got = 0; writes = 0; wd = 'x;
    for (int c = 1; c <= 2 * len + 3; c++) begin
      abort = (c == abort_cycle);
      @(negedge clk);
      if (mem_enable_write) writes++;
      check("busy_in_copy", {busy, start_ready}, 2'b10);
      if (done) begin
        got = c;
        wd  = words_done;
        break;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    check("done_cycle", got, exp_done);
    check("words_done", wd, k);
    check("write_cycles", writes, k);
`ifdef MEM_COPY_BACKWARD_EN
    check("backward_flag", backward, model_overlap(src, dst, len));
`endif
    model_copy(src, dst, len, k);
    @(posedge clk); #1;
    check("idle_after_done", {start_ready, busy, done}, 3'b100);
    check_mem("mem_contents");
  endtask

  initial begin
    int src, dst, len, ab, got;
    rst_n = 1'b0; start_valid = 1'b0; src_addr = '0; dst_addr = '0; len_in = '0; abort = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i]   = op_t'($urandom);
      model[i] = mem[i];
    end
    #12;
    check("rst_ready_busy_done", {start_ready, busy, done}, 3'b100);
    check("rst_words_done", words_done, 0);
    check("rst_mem_port", {mem_addr, mem_enable_write, mem_write_data}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    abort = 1'b1;  // ignored in IDLE
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_ignored_idle", {start_ready, busy}, 2'b10);

    // Basic four-word copy
    for (int i = 0; i < 4; i++) begin
      mem[8'h10 + i]   = op_t'(16'hA + i);
      model[8'h10 + i] = op_t'(16'hA + i);
    end
    run_copy(8'h10, 8'h40, 4, 0);
    // Zero-length
    run_copy(8'h30, 8'h70, 0, 0);
    // Abort in 3rd READ, then in 3rd WRITE
    run_copy(8'h10, 8'h80, 8, 5);
    run_copy(8'h10, 8'h90, 8, 6);

    // Overlapping copy with dst just above src
    for (int i = 0; i < 4; i++) begin
      mem[8'h20 + i]   = op_t'(i + 1);
      model[8'h20 + i] = op_t'(i + 1);
    end
    run_copy(8'h20, 8'h21, 4, 0);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_COPY_BACKWARD_EN
      check("overlap_word", mem[8'h21 + i], i + 1);
`else
      check("overlap_word", mem[8'h21 + i], 1);
`endif
    end

    // Address wrap, forward and (when enabled) backward
    run_copy(8'hFE, 8'h30, 4, 0);
    run_copy(8'hFE, 8'hFF, 3, 0);

    // Reset during the WRITE of word 2
    start_valid = 1'b1; src_addr = 8'h10; dst_addr = 8'h60; len_in = 8;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("wr_before_reset", {mem_enable_write, mem_addr}, {1'b1, 8'h61});
    #1 rst_n = 1'b0;
    #1;
    check("async_we_drop", mem_enable_write, 0);
    check("async_idle", {start_ready, busy}, 2'b10);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_idle", {start_ready, busy, mem_enable_write}, 3'b100);
    model_copy(8'h10, 8'h60, 8, 1);
    repeat (3) @(posedge clk);
    #1 check_mem("mem_after_reset");

    // Request held high through a busy copy
    start_valid = 1'b1; src_addr = 8'h10; dst_addr = 8'hA0; len_in = 3;
    @(posedge clk); #1;
    src_addr = 8'h50; dst_addr = 8'hB0; len_in = 2;
    got = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check("held_not_ready", start_ready, 0);
      if (done && got == 0) got = c;
      @(posedge clk); #1;
    end
    check("held_first_done", got, 7);
    @(negedge clk);
    check("held_ready_after_done", {start_ready, busy}, 2'b10);
    @(posedge clk); #1;
    start_valid = 1'b0;
    got = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) check("second_read_addr", {busy, mem_addr}, {1'b1, 8'h50});
      if (done) begin got = c; break; end
      @(posedge clk); #1;
    end
    check("second_done_cycle", got, 5);
    model_copy(8'h10, 8'hA0, 3, 3);
    model_copy(8'h50, 8'hB0, 2, 2);
    @(posedge clk); #1;
    check_mem("mem_after_held");

    // Randomized copies, some aborted
    for (int n = 0; n < 25; n++) begin
      src = int'($urandom_range(0, 255));
      dst = int'($urandom_range(0, 255));
      len = int'($urandom_range(0, 10));
      ab  = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * len)) : 0;
      run_copy(src, dst, len, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
